// File: rtl/instr_encoder_if.sv
// Command handshake between the boot/test loader and the instruction encoder.
interface instr_encoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [7:0] cmd_b;

    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_a, cmd_b, output cmd_ready);
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction commands into 9-bit ISA words and writes them
// sequentially into instruction memory, with LIT8 expansion and done-word append.
//
// state   | meaning
// IDLE    | accepting commands (ready unless full)
// LIT_HI2 | writing second word of LIT8, not ready
// FIN     | done word on the write port
// STOP    | halted; waits for start
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    instr_encoder_if.slave    cmd,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, LIT_HI2, FIN, STOP} state_t;

    localparam logic [3:0]        OP_LIT8   = 4'd2;
    localparam logic [3:0]        OP_MOV    = 4'd3;
    localparam logic [8:0]        DONE_WORD = 9'h1F4;
    localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [3:0]        lit_hi_q;
    logic              fin_pend_q;

    logic       wr_d;
    logic [8:0] word_d;
    logic       set_err, set_done, fin_take, fin_arm, lit_load;
    logic       accept, mov_bad, last_slot;

    function automatic logic [8:0] encode(input logic [3:0] op, input logic [3:0] a,
                                          input logic [7:0] b);
        logic [8:0] w;
        case (op)
            4'd0:    w = {5'b00000, a};
            4'd1:    w = {5'b00001, a};
            4'd2:    w = {5'b00000, b[3:0]};
            4'd3:    w = {1'b0, a, b[3:0]};
            4'd4:    w = {5'b01111, b[3:0]};
            4'd5:    w = {4'b1000, 1'b0, b[0], a[2:0]};
            4'd6:    w = {4'b1000, 1'b1, b[0], a[2:0]};
            4'd7:    w = {5'b10010, a};
            4'd8:    w = {5'b10011, a};
            4'd9:    w = {4'b1010, b[0], a};
            4'd10:   w = {4'b1011, b[0], a};
            4'd11:   w = {4'b1100, b[0], a};
            4'd12:   w = {4'b1101, b[0], a};
            4'd13:   w = {4'b1110, b[0], a};
            4'd14:   w = {5'b11110, a};
            default: w = {5'b11111, a};
        endcase
        return w;
    endfunction

    // MOV destinations 0/1 would decode as literals and 15 as JSR
    assign mov_bad   = (cmd.cmd_a < 4'd2) || (cmd.cmd_a == 4'd15);
    assign last_slot = (ptr_q == PTR_MAX);
    assign cmd.cmd_ready = (state_q == IDLE) && !full && !done && !fin_pend_q && !start;
    assign accept    = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = 1'b0;
        word_d   = encode(cmd.cmd_op, cmd.cmd_a, cmd.cmd_b);
        set_err  = 1'b0;
        set_done = 1'b0;
        fin_take = 1'b0;
        lit_load = 1'b0;
        fin_arm  = finish && ((state_q == IDLE) || (state_q == LIT_HI2));
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_LIT8) begin
                        if (last_slot) begin
                            set_err = 1'b1;
                        end else begin
                            wr_d     = 1'b1;
                            lit_load = 1'b1;
                            state_d  = LIT_HI2;
                        end
                    end else if ((cmd.cmd_op == OP_MOV) && mov_bad) begin
                        set_err = 1'b1;
                    end else begin
                        wr_d = 1'b1;
                    end
                end else if (finish || fin_pend_q) begin
                    fin_take = 1'b1;
                    if (full) begin
                        set_err = 1'b1;
                        state_d = STOP;
                    end else begin
                        wr_d    = 1'b1;
                        word_d  = DONE_WORD;
                        state_d = FIN;
                    end
                end
            end
            LIT_HI2: begin
                wr_d    = 1'b1;
                word_d  = {5'b00001, lit_hi_q};
                state_d = IDLE;
            end
            FIN: begin
                set_done = 1'b1;
                state_d  = STOP;
            end
            default: ;
        endcase
        if (start) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            lit_hi_q   <= '0;
            fin_pend_q <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            ptr_q      <= start_addr;
            fin_pend_q <= 1'b0;
            imem_we    <= 1'b0;
            count      <= '0;
            err        <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            imem_we <= wr_d;
            count   <= count + {{ADDR_W{1'b0}}, imem_we};
            if (wr_d) begin
                imem_addr  <= ptr_q;
                imem_wdata <= word_d;
                // pointer saturates at the top slot; full blocks further writes
                if (last_slot) begin
                    full <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + PTR_ONE;
                end
            end
            if (lit_load) begin
                lit_hi_q <= cmd.cmd_b[7:4];
            end
            err        <= err | set_err;
            done       <= done | set_done;
            fin_pend_q <= (fin_pend_q | fin_arm) & ~fin_take;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and random commands on an 8-bit and a 2-bit
// address instance, checked against a queue-based memory-write model.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start8 = 1'b0, start2 = 1'b0, finish8 = 1'b0, finish2 = 1'b0;
    logic [7:0] sa8 = '0;
    logic [1:0] sa2 = '0;
    logic       we8, we2, err8, err2, full8, full2, done8, done2;
    logic [7:0] addr8;
    logic [1:0] addr2;
    logic [8:0] wd8, wd2, cnt8;
    logic [2:0] cnt2;

    instr_encoder_if if8();
    instr_encoder_if if2();

    instr_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .start_addr(sa8), .cmd(if8.slave),
        .finish(finish8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
        .count(cnt8), .err(err8), .full(full8), .done(done8));

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .start_addr(sa2), .cmd(if2.slave),
        .finish(finish2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .count(cnt2), .err(err2), .full(full2), .done(done2));

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int wcyc8[$];
    int q_addr8[$], q_data8[$], q_addr2[$], q_data2[$];
    int m_ptr[2], m_cnt[2], depth[2];
    bit m_err[2], m_done[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference word from the ISA table, as plain arithmetic
    function automatic int ref_word(input int op, input int a, input int b);
        int b0 = b % 2;
        case (op)
            0:       return a;
            1:       return 16 + a;
            3:       return a * 16 + b % 16;
            4:       return 240 + b % 16;
            5:       return 256 + 8 * b0 + a % 8;
            6:       return 272 + 8 * b0 + a % 8;
            7:       return 288 + a;
            8:       return 304 + a;
            9:       return 320 + 16 * b0 + a;
            10:      return 352 + 16 * b0 + a;
            11:      return 384 + 16 * b0 + a;
            12:      return 416 + 16 * b0 + a;
            13:      return 448 + 16 * b0 + a;
            14:      return 480 + a;
            default: return 496 + a;
        endcase
    endfunction

    function automatic void push(input bit d, input int w);
        if (d) begin q_addr2.push_back(m_ptr[1]); q_data2.push_back(w); end
        else   begin q_addr8.push_back(m_ptr[0]); q_data8.push_back(w); end
        m_ptr[d]++;
        m_cnt[d]++;
    endfunction

    function automatic void model_cmd(input bit d, input int op, input int a, input int b);
        if (op == 3 && (a < 2 || a == 15)) m_err[d] = 1'b1;
        else if (op == 2) begin
            if (depth[d] - m_ptr[d] < 2) m_err[d] = 1'b1;
            else begin push(d, b % 16); push(d, 16 + b / 16); end
        end else push(d, ref_word(op, a, b));
    endfunction

    always @(negedge clk) if (we8) begin
        wcyc8.push_back(cyc);
        chk("dut8 write expected", 32'(q_addr8.size() > 0), 1);
        if (q_addr8.size() > 0) begin
            chk("dut8 imem_addr", 32'(addr8), q_addr8.pop_front());
            chk("dut8 imem_wdata", 32'(wd8), q_data8.pop_front());
        end
    end

    always @(negedge clk) if (we2) begin
        chk("dut2 write expected", 32'(q_addr2.size() > 0), 1);
        if (q_addr2.size() > 0) begin
            chk("dut2 imem_addr", 32'(addr2), q_addr2.pop_front());
            chk("dut2 imem_wdata", 32'(wd2), q_data2.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit d, input logic [3:0] op, input logic [3:0] a, input logic [7:0] b);
        int  n = 0;
        logic rdy;
        if (d) begin if2.cmd_valid = 1'b1; if2.cmd_op = op; if2.cmd_a = a; if2.cmd_b = b; end
        else   begin if8.cmd_valid = 1'b1; if8.cmd_op = op; if8.cmd_a = a; if8.cmd_b = b; end
        forever begin
            @(negedge clk);
            rdy = d ? if2.cmd_ready : if8.cmd_ready;
            if (rdy === 1'b1) break;
            n++;
            if (n > 30) break;
        end
        if (rdy !== 1'b1) begin
            chk("cmd_ready timeout", 32'(rdy), 1);
            #1;
        end else begin
            @(posedge clk);
            #1;
            model_cmd(d, int'(op), int'(a), int'(b));
        end
        if2.cmd_valid = 1'b0;
        if8.cmd_valid = 1'b0;
    endtask

    task automatic do_start(input bit d, input int addr);
        if (d) begin start2 = 1'b1; sa2 = 2'(addr); end
        else   begin start8 = 1'b1; sa8 = 8'(addr); end
        @(posedge clk);
        #1;
        start2 = 1'b0;
        start8 = 1'b0;
        m_ptr[d] = addr; m_cnt[d] = 0; m_err[d] = 1'b0; m_done[d] = 1'b0;
    endtask

    task automatic do_fin(input bit d);
        bit was_full;
        was_full = (m_ptr[d] == depth[d]);
        if (d) finish2 = 1'b1; else finish8 = 1'b1;
        @(posedge clk);
        #1;
        finish2 = 1'b0;
        finish8 = 1'b0;
        if (was_full) m_err[d] = 1'b1; else push(d, 'h1F4);
        @(negedge clk);
        chk("done low while done word written", 32'(d ? done2 : done8), 0);
        @(posedge clk);
        #1;
        if (!was_full) m_done[d] = 1'b1;
        @(negedge clk);
        chk("done after finish", 32'(d ? done2 : done8), 32'(m_done[d]));
        chk("cmd_ready low after finish", 32'(d ? if2.cmd_ready : if8.cmd_ready), 0);
    endtask

    task automatic check_state(input bit d, input string tag);
        idle(3);
        if (d) begin
            chk({tag, " count"}, 32'(cnt2), m_cnt[1]);
            chk({tag, " err"}, 32'(err2), 32'(m_err[1]));
            chk({tag, " full"}, 32'(full2), 32'(m_ptr[1] == depth[1]));
            chk({tag, " done"}, 32'(done2), 32'(m_done[1]));
            chk({tag, " writes outstanding"}, 32'(q_addr2.size()), 0);
        end else begin
            chk({tag, " count"}, 32'(cnt8), m_cnt[0]);
            chk({tag, " err"}, 32'(err8), 32'(m_err[0]));
            chk({tag, " full"}, 32'(full8), 32'(m_ptr[0] == depth[0]));
            chk({tag, " done"}, 32'(done8), 32'(m_done[0]));
            chk({tag, " writes outstanding"}, 32'(q_addr8.size()), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        depth[0] = 256; depth[1] = 4;
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0; m_done[i] = 1'b0;
        end
        if8.cmd_valid = 1'b0; if8.cmd_op = '0; if8.cmd_a = '0; if8.cmd_b = '0;
        if2.cmd_valid = 1'b0; if2.cmd_op = '0; if2.cmd_a = '0; if2.cmd_b = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset cmd_ready", 32'(if8.cmd_ready), 0);
        chk("reset cmd_ready dut2", 32'(if2.cmd_ready), 0);
        chk("reset imem_we", 32'(we8), 0);
        chk("reset imem_addr", 32'(addr8), 0);
        chk("reset imem_wdata", 32'(wd8), 0);
        check_state(0, "reset");

        // MOV/JSR back-to-back from 0x10
        do_start(0, 'h10);
        wcyc8.delete();
        send(0, 4'd3, 4'd3, 8'h05);
        send(0, 4'd4, 4'd0, 8'h03);
        check_state(0, "mov/jsr");
        chk("mov/jsr no idle cycle", 32'(wcyc8[1] - wcyc8[0]), 1);

        // LIT8 then STORE
        wcyc8.delete();
        send(0, 4'd2, 4'd0, 8'hA7);
        @(negedge clk);
        chk("cmd_ready low during LIT8 high word", 32'(if8.cmd_ready), 0);
        send(0, 4'd6, 4'd5, 8'h01);
        check_state(0, "lit8/store");
        chk("lit8 words consecutive", 32'(wcyc8[1] - wcyc8[0]), 1);
        chk("store right after lit8", 32'(wcyc8[2] - wcyc8[1]), 1);

        send(0, 4'd12, 4'd6, 8'h01);
        send(0, 4'd10, 4'd9, 8'h01);
        send(0, 4'd7, 4'd15, 8'h00);
        check_state(0, "alu/br/inc");

        // Illegal MOV destinations, then a legal write at the unchanged pointer
        send(0, 4'd3, 4'd1, 8'h22);
        send(0, 4'd3, 4'd15, 8'h22);
        check_state(0, "illegal mov");
        send(0, 4'd8, 4'd2, 8'h00);
        check_state(0, "after illegal mov");

        // Random command stream, ending in LIT8 with a same-cycle finish
        do_start(0, $urandom_range(0, 'h80));
        for (int i = 0; i < 40; i++) begin
            send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        check_state(0, "random");
        finish8 = 1'b1;
        send(0, 4'd2, 4'd0, 8'($urandom_range(0, 255)));
        finish8 = 1'b0;
        push(0, 'h1F4);
        m_done[0] = 1'b1;
        check_state(0, "lit8 with finish");
        chk("cmd_ready after pending finish", 32'(if8.cmd_ready), 0);

        // Three words from 0, then finish; start clears flags
        do_start(0, 0);
        send(0, 4'd0, 4'd1, 8'h00);
        send(0, 4'd1, 4'd2, 8'h00);
        send(0, 4'd15, 4'd4, 8'h00);
        check_state(0, "func 4 no done");
        do_fin(0);
        check_state(0, "finish after 3");
        do_start(0, 0);
        check_state(0, "start clears");
        chk("cmd_ready after start", 32'(if8.cmd_ready), 1);

        // Two-bit address instance: last-slot LIT8 rejection, full, finish when full
        do_start(1, 2);
        send(1, 4'd7, 4'd3, 8'h00);
        send(1, 4'd2, 4'd0, 8'h5C);
        send(1, 4'd7, 4'd4, 8'h00);
        check_state(1, "small full");
        chk("cmd_ready low when full", 32'(if2.cmd_ready), 0);
        do_fin(1);
        check_state(1, "finish when full");
        do_start(1, 0);
        check_state(1, "small start clears");
        chk("dut2 cmd_ready after start", 32'(if2.cmd_ready), 1);

        // Reset between the two LIT8 words drops the second one
        send(0, 4'd2, 4'd0, 8'h3C);
        void'(q_addr8.pop_back());
        void'(q_data8.pop_back());
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0; m_done[i] = 1'b0;
        end
        @(negedge clk);
        chk("mid-lit8 reset imem_we", 32'(we8), 0);
        chk("mid-lit8 reset imem_addr", 32'(addr8), 0);
        chk("mid-lit8 reset imem_wdata", 32'(wd8), 0);
        chk("mid-lit8 reset cmd_ready", 32'(if8.cmd_ready), 0);
        check_state(0, "mid-lit8 reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
